note_sequencer: RTL and testbench

Parametrised successor to the four-note button sequencer. It drives a single buzzer channel from a table of NUM_NOTES tone divisors. There are two modes:
- manual step: each debounced button press advances to the next note.
- auto play: a note-duration timer advances the note; a press restarts the sequence.

Everything runs on the single board clock using clock enables; there are no derived clocks. The block sits between the board button/mode inputs and the buzzer pin.

---
 rtl/note_sequencer.sv | 133 +++++++++++++
 tb/tb_note_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Single-channel buzzer sequencer: steps through a table of tone divisors either on
// debounced button presses (manual) or on a note-duration timer (auto play).
module note_sequencer #(
    parameter int NUM_NOTES = 8,
    parameter int DIV_W     = 16,
    parameter logic [NUM_NOTES*DIV_W-1:0] NOTE_DIVS = {
        16'd22933, 16'd24297, 16'd27273, 16'd30612,
        16'd34361, 16'd36404, 16'd40863, 16'd45866},
    parameter int TICK_DIV  = 3000000,
    parameter int DEBOUNCE  = 240000,
    localparam int IDX_W    = $clog2(NUM_NOTES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic             mode,
    input  logic             enable,
    output logic             ch_out,
    output logic [IDX_W-1:0] note_idx,
    output logic             step_pulse
);

    localparam int DCNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_NOTES - 1);

    logic              b1_q, b1_d;
    logic              b2_q, b2_d;
    logic              db_q, db_d;
    logic              db_last_q, db_last_d;
    logic              press_q, press_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              step_q, step_d;
    logic [DIV_W-1:0]  tc_q, tc_d;
    logic              ch_q, ch_d;

    logic              auto_run;
    logic              tick;
    logic              update;
    logic [IDX_W-1:0]  idx_inc;
    logic [DIV_W-1:0]  div;

    // Button synchroniser, debounce counter and rising-edge press detector.
    always_comb begin
        b1_d      = button;
        b2_d      = b1_q;
        db_d      = db_q;
        dcnt_d    = '0;
        if (b2_q != db_q) begin
            if (dcnt_q == DCNT_LAST) begin
                db_d = b2_q;
            end else begin
                dcnt_d = dcnt_q + DCNT_W'(1);
            end
        end
        db_last_d = db_q;
        press_d   = db_q & ~db_last_q;
    end

    always_comb begin
        div = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                div = NOTE_DIVS[i*DIV_W +: DIV_W];
            end
        end
    end

    // A press in auto mode restarts at note 0 and takes priority over a coincident tick.
    always_comb begin
        auto_run = enable & mode;
        tick     = auto_run && (tcnt_q == TCNT_LAST);
        update   = enable && (press_q || tick);
        idx_inc  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

        idx_d = idx_q;
        if (update) begin
            idx_d = (mode && press_q) ? '0 : idx_inc;
        end
        step_d = update;

        tcnt_d = '0;
        if (auto_run && !press_q && !tick) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
        end
    end

    // Tone counter restarts on every note change so each note begins with a high half.
    always_comb begin
        tc_d = '0;
        if (enable && !update && (div != '0)) begin
            tc_d = (tc_q == div - DIV_W'(1)) ? '0 : tc_q + DIV_W'(1);
        end
        ch_d = enable && (tc_q < (div >> 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b1_q      <= 1'b0;
            b2_q      <= 1'b0;
            db_q      <= 1'b0;
            db_last_q <= 1'b0;
            press_q   <= 1'b0;
            dcnt_q    <= '0;
            tcnt_q    <= '0;
            idx_q     <= '0;
            step_q    <= 1'b0;
            tc_q      <= '0;
            ch_q      <= 1'b0;
        end else begin
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            db_q      <= db_d;
            db_last_q <= db_last_d;
            press_q   <= press_d;
            dcnt_q    <= dcnt_d;
            tcnt_q    <= tcnt_d;
            idx_q     <= idx_d;
            step_q    <= step_d;
            tc_q      <= tc_d;
            ch_q      <= ch_d;
        end
    end

    assign ch_out     = ch_q;
    assign note_idx   = idx_q;
    assign step_pulse = step_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: a 4-note main instance plus a second instance
// whose table holds a rest (0) and a divisor of 1.
module tb_note_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, button, mode, enable, ch_out, step_pulse;
    logic [1:0] note_idx;
    logic       r_rst, r_button, r_mode, r_enable, r_ch, r_step;
    logic [1:0] r_idx;

    int n_asrt = 0;
    int n_fail = 0;

    note_sequencer #(
        .NUM_NOTES(4), .DIV_W(16),
        .NOTE_DIVS({16'd14, 16'd12, 16'd10, 16'd8}),
        .TICK_DIV(50), .DEBOUNCE(4)
    ) u_dut (
        .clk(clk), .rst(rst), .button(button), .mode(mode), .enable(enable),
        .ch_out(ch_out), .note_idx(note_idx), .step_pulse(step_pulse)
    );

    note_sequencer #(
        .NUM_NOTES(4), .DIV_W(16),
        .NOTE_DIVS({16'd4, 16'd1, 16'd0, 16'd6}),
        .TICK_DIV(50), .DEBOUNCE(4)
    ) u_rest (
        .clk(clk), .rst(r_rst), .button(r_button), .mode(r_mode), .enable(r_enable),
        .ch_out(r_ch), .note_idx(r_idx), .step_pulse(r_step)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Hold the button from the next edge; the step must land on exactly the 8th edge,
    // then the new note's square wave is checked for 16 cycles.
    task automatic press(input bit rd, input int prev, input int nxt, input int d);
        if (rd) r_button = 1'b1; else button = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            cyc(1);
            chk("pre_step", rd ? r_step : step_pulse, 0);
            chk("pre_idx", rd ? r_idx : note_idx, prev);
        end
        cyc(1);
        chk("step_idx", rd ? r_idx : note_idx, nxt);
        chk("step_pulse", rd ? r_step : step_pulse, 1);
        for (int j = 1; j <= 16; j++) begin
            cyc(1);
            if (j == 1) chk("step_one_cycle", rd ? r_step : step_pulse, 0);
            chk("tone", rd ? r_ch : ch_out, (d != 0 && ((j - 1) % d) < d / 2) ? 1 : 0);
        end
        if (rd) r_button = 1'b0; else button = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            chk("release_no_step", rd ? r_step : step_pulse, 0);
        end
    endtask

    initial begin
        rst = 1'b1; button = 1'b0; mode = 1'b0; enable = 1'b0;
        r_rst = 1'b1; r_button = 1'b0; r_mode = 1'b0; r_enable = 1'b0;
        @(negedge clk);
        cyc(3);
        chk("rst_idx", note_idx, 0);
        chk("rst_ch", ch_out, 0);
        chk("rst_step", step_pulse, 0);

        rst = 1'b0; enable = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            cyc(1);
            chk("idle_tone", ch_out, (((j - 1) % 8) < 4) ? 1 : 0);
            chk("idle_step", step_pulse, 0);
            chk("idle_idx", note_idx, 0);
        end

        // Three-cycle glitch falls one cycle short of the debounce window.
        button = 1'b1;
        cyc(3);
        button = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            chk("glitch_step", step_pulse, 0);
            chk("glitch_idx", note_idx, 0);
        end

        press(1'b0, 0, 1, 10);
        press(1'b0, 1, 2, 12);
        press(1'b0, 2, 3, 14);
        press(1'b0, 3, 0, 8);

        mode = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            cyc(49);
            chk("auto_hold_idx", note_idx, (n - 1) % 4);
            chk("auto_hold_step", step_pulse, 0);
            cyc(1);
            chk("auto_adv_idx", note_idx, n % 4);
            chk("auto_adv_step", step_pulse, 1);
        end

        // Press timed so its update edge coincides with the next tick.
        cyc(42);
        button = 1'b1;
        cyc(7);
        chk("pt_pre_idx", note_idx, 1);
        cyc(1);
        chk("pt_idx", note_idx, 0);
        chk("pt_step", step_pulse, 1);
        button = 1'b0;
        cyc(49);
        chk("pt_hold_idx", note_idx, 0);
        chk("pt_hold_step", step_pulse, 0);
        cyc(1);
        chk("pt_adv_idx", note_idx, 1);
        chk("pt_adv_step", step_pulse, 1);

        cyc(2);
        chk("en_pre_ch", ch_out, 1);
        enable = 1'b0;
        cyc(1);
        chk("dis_ch", ch_out, 0);
        chk("dis_idx", note_idx, 1);
        button = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            chk("dis_step", step_pulse, 0);
            chk("dis_press_idx", note_idx, 1);
            chk("dis_press_ch", ch_out, 0);
        end
        button = 1'b0;
        cyc(10);
        chk("dis_release_idx", note_idx, 1);
        enable = 1'b1;
        cyc(1);
        chk("reen_ch", ch_out, 1);
        chk("reen_idx", note_idx, 1);
        cyc(48);
        chk("reen_hold_idx", note_idx, 1);
        chk("reen_hold_step", step_pulse, 0);
        cyc(1);
        chk("reen_adv_idx", note_idx, 2);
        chk("reen_adv_step", step_pulse, 1);
        cyc(1);
        chk("pre_rst_ch", ch_out, 1);

        rst = 1'b1;
        cyc(1);
        chk("mid_rst_idx", note_idx, 0);
        chk("mid_rst_ch", ch_out, 0);
        chk("mid_rst_step", step_pulse, 0);
        rst = 1'b0;
        cyc(1);
        chk("post_rst_ch", ch_out, 1);
        cyc(48);
        chk("post_rst_hold_idx", note_idx, 0);
        chk("post_rst_hold_step", step_pulse, 0);
        cyc(1);
        chk("post_rst_adv_idx", note_idx, 1);
        chk("post_rst_adv_step", step_pulse, 1);

        r_rst = 1'b0; r_enable = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            cyc(1);
            chk("rest_tbl_tone0", r_ch, (((j - 1) % 6) < 3) ? 1 : 0);
        end
        press(1'b1, 0, 1, 0);
        press(1'b1, 1, 2, 1);
        press(1'b1, 2, 3, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
